usb_rx_gen: RTL and testbench

//  Parametrised USB serial receiver. Successor to the fixed 8-bit LS/FS receiver.

---
 rtl/usb_rx_gen_pkg.sv | 35 +++
 rtl/usb_rx_gen_nrzi_unstuff.sv | 55 +++++
 rtl/usb_rx_gen.sv | 202 ++++++++++++++++++++
 tb/tb_usb_rx_gen.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_gen_pkg.sv
// Shared types for the parametrised USB serial receiver.
package usb_rx_gen_pkg;

    // Line state delivered by the clock/data-recovery block.
    typedef enum logic [1:0] {
        D_SE0 = 2'b00,
        D_J   = 2'b01,
        D_K   = 2'b10,
        D_SE1 = 2'b11
    } d_port_t;

    // Packet status / cause of the most recent error.
    typedef enum logic [2:0] {
        RX_OK     = 3'd0,
        ERR_STUFF = 3'd1,
        ERR_SE1   = 3'd2,
        ERR_EOP   = 3'd3,
        ERR_ALIGN = 3'd4
    } rx_err_t;

    // Receiver packet-level states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_DATA  = 3'd2,
        S_EOP   = 3'd3,
        S_ABORT = 3'd4
    } rx_state_t;

    // True for the two differential data levels (the only ones carrying a bit).
    function automatic logic is_jk(input d_port_t s);
        return (s == D_J) || (s == D_K);
    endfunction

endpackage

// File: rtl/usb_rx_gen_nrzi_unstuff.sv
// NRZI decoder and bit unstuffer; outputs are combinational views of the
// current sample so the packet FSM can act on the same strobe.
module usb_nrzi_unstuff
    import usb_rx_gen_pkg::*;
#(
    parameter int unsigned STUFF_LEN = 6
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    clk_en,
    input  d_port_t rxd,
    input  logic    sync_start,
    output logic    bit_o,
    output logic    bit_en,
    output logic    stuff_err
);

    localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);

    d_port_t           prev_lvl;
    logic [ONES_W-1:0] ones_cnt;
    logic              jk_c;
    logic              at_limit_c;

    // Decode the current sample against the line history and stuffing state.
    always_comb begin
        jk_c       = clk_en && is_jk(rxd);
        at_limit_c = (ones_cnt == ONES_W'(STUFF_LEN));
        bit_o      = (rxd == prev_lvl);
        bit_en     = jk_c && !at_limit_c;
        stuff_err  = jk_c && at_limit_c && bit_o;
    end

    // Line history follows every J/K; ones counter restarts at SYNC end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_lvl <= D_J;
            ones_cnt <= '0;
        end else if (clk_en) begin
            if (jk_c) begin
                prev_lvl <= rxd;
            end
            if (sync_start) begin
                ones_cnt <= '0;
            end else if (jk_c) begin
                if (at_limit_c || !bit_o) begin
                    ones_cnt <= '0;
                end else begin
                    ones_cnt <= ones_cnt + ONES_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/usb_rx_gen.sv
// Parametrised USB receiver: SYNC detect, word assembly, EOP and error handling.
module usb_rx_gen
    import usb_rx_gen_pkg::*;
#(
    parameter int unsigned SYNC_LEN  = 8,
    parameter int unsigned STUFF_LEN = 6,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned EOP_SE0   = 2,
    parameter int unsigned IDLE_LEN  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  d_port_t           rxd,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              active,
    output logic              eop,
    output logic              error,
    output rx_err_t           err_code
);

    localparam int unsigned SYNC_W = $clog2(SYNC_LEN);
    localparam int unsigned BIT_W  = $clog2(DATA_W);
    localparam int unsigned SE0_W  = 2;
    localparam int unsigned IDLE_W = $clog2(IDLE_LEN + 1);

    rx_state_t         state, state_n;
    logic [SYNC_W-1:0] sync_cnt, sync_cnt_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [SE0_W-1:0]  se0_cnt, se0_cnt_n;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
    logic [DATA_W-2:0] shift, shift_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n, active_n, eop_n, error_n;
    logic              done, done_n;
    rx_err_t           err_code_n;

    logic              sync_start_c;
    logic              bit_c, bit_en_c, stuff_err_c;
    logic [DATA_W-1:0] word_c;
    d_port_t           sync_expect_c;

    usb_nrzi_unstuff #(
        .STUFF_LEN(STUFF_LEN)
    ) u_nrzi (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .rxd       (rxd),
        .sync_start(sync_start_c),
        .bit_o     (bit_c),
        .bit_en    (bit_en_c),
        .stuff_err (stuff_err_c)
    );

    // Next-state and next-output logic; pulses default low every clock.
    always_comb begin
        state_n       = state;
        sync_cnt_n    = sync_cnt;
        bit_cnt_n     = bit_cnt;
        se0_cnt_n     = se0_cnt;
        idle_cnt_n    = idle_cnt;
        shift_n       = shift;
        data_n        = data;
        valid_n       = 1'b0;
        eop_n         = 1'b0;
        error_n       = 1'b0;
        done_n        = 1'b0;
        active_n      = done ? 1'b0 : active;
        err_code_n    = err_code;
        sync_start_c  = 1'b0;
        word_c        = {bit_c, shift};
        sync_expect_c = (sync_cnt >= SYNC_W'(SYNC_LEN - 2)) ? D_K
                      : (sync_cnt[0] ? D_J : D_K);

        if (clk_en) begin
            case (state)
                S_IDLE: begin
                    if (rxd == D_K) begin
                        state_n    = S_SYNC;
                        sync_cnt_n = SYNC_W'(1);
                        err_code_n = RX_OK;
                    end
                end
                S_SYNC: begin
                    if (rxd != sync_expect_c) begin
                        state_n = S_IDLE;
                    end else if (sync_cnt == SYNC_W'(SYNC_LEN - 1)) begin
                        state_n      = S_DATA;
                        active_n     = 1'b1;
                        bit_cnt_n    = '0;
                        sync_start_c = 1'b1;
                    end else begin
                        sync_cnt_n = sync_cnt + SYNC_W'(1);
                    end
                end
                S_DATA: begin
                    case (rxd)
                        D_SE0: begin
                            state_n   = S_EOP;
                            se0_cnt_n = SE0_W'(1);
                        end
                        D_SE1: begin
                            state_n    = S_ABORT;
                            error_n    = 1'b1;
                            err_code_n = ERR_SE1;
                            idle_cnt_n = '0;
                        end
                        default: begin
                            if (stuff_err_c) begin
                                state_n    = S_ABORT;
                                error_n    = 1'b1;
                                err_code_n = ERR_STUFF;
                                idle_cnt_n = '0;
                            end else if (bit_en_c) begin
                                shift_n = word_c[DATA_W-1:1];
                                if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                                    data_n    = word_c;
                                    valid_n   = 1'b1;
                                    bit_cnt_n = '0;
                                end else begin
                                    bit_cnt_n = bit_cnt + BIT_W'(1);
                                end
                            end
                        end
                    endcase
                end
                S_EOP: begin
                    if (rxd == D_SE0) begin
                        if (se0_cnt != '1) begin
                            se0_cnt_n = se0_cnt + SE0_W'(1);
                        end
                    end else if (rxd == D_J && se0_cnt >= SE0_W'(EOP_SE0)) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        // A single trailing dribble bit is tolerated.
                        if (bit_cnt <= BIT_W'(1)) begin
                            eop_n = 1'b1;
                        end else begin
                            error_n    = 1'b1;
                            err_code_n = ERR_ALIGN;
                        end
                    end else begin
                        state_n    = S_ABORT;
                        error_n    = 1'b1;
                        err_code_n = ERR_EOP;
                        idle_cnt_n = '0;
                    end
                end
                S_ABORT: begin
                    if (rxd == D_J) begin
                        if (idle_cnt == IDLE_W'(IDLE_LEN - 1)) begin
                            state_n    = S_IDLE;
                            idle_cnt_n = '0;
                            done_n     = 1'b1;
                        end else begin
                            idle_cnt_n = idle_cnt + IDLE_W'(1);
                        end
                    end else if (rxd != D_SE0) begin
                        idle_cnt_n = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            sync_cnt <= '0;
            bit_cnt  <= '0;
            se0_cnt  <= '0;
            idle_cnt <= '0;
            shift    <= '0;
            data     <= '0;
            valid    <= 1'b0;
            active   <= 1'b0;
            eop      <= 1'b0;
            error    <= 1'b0;
            done     <= 1'b0;
            err_code <= RX_OK;
        end else begin
            state    <= state_n;
            sync_cnt <= sync_cnt_n;
            bit_cnt  <= bit_cnt_n;
            se0_cnt  <= se0_cnt_n;
            idle_cnt <= idle_cnt_n;
            shift    <= shift_n;
            data     <= data_n;
            valid    <= valid_n;
            active   <= active_n;
            eop      <= eop_n;
            error    <= error_n;
            done     <= done_n;
            err_code <= err_code_n;
        end
    end

endmodule

// File: tb/tb_usb_rx_gen.sv
// Self-checking bench for usb_rx_gen: an 8-bit default instance and a
// 16-bit / 32-symbol-SYNC instance, driven from a line-level packet model.
module tb_usb_rx_gen;
    import usb_rx_gen_pkg::*;

    logic        clk;
    logic        reset;
    logic        clk_en;
    d_port_t     rxd8, rxd16;
    logic [7:0]  data8;
    logic [15:0] data16;
    logic        valid8, active8, eop8, error8;
    logic        valid16, active16, eop16, error16;
    rx_err_t     err_code8, err_code16;

    int pass_n  = 0;
    int check_n = 0;

    logic [15:0] wq8[$];
    logic [15:0] wq16[$];
    int          eops8 = 0, eops16 = 0, errs8 = 0, errs16 = 0;
    rx_err_t     lerr8 = RX_OK, lerr16 = RX_OK;

    d_port_t     sq[$];
    d_port_t     lvl;
    int          ones;
    logic [15:0] expw[$];

    usb_rx_gen u8 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .rxd(rxd8),
        .data(data8), .valid(valid8), .active(active8), .eop(eop8),
        .error(error8), .err_code(err_code8)
    );

    usb_rx_gen #(.SYNC_LEN(32), .DATA_W(16)) u16 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .rxd(rxd16),
        .data(data16), .valid(valid16), .active(active16), .eop(eop16),
        .error(error16), .err_code(err_code16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output pulse just after the active edge.
    always @(posedge clk) begin
        #1;
        if (valid8)  wq8.push_back(16'(data8));
        if (eop8)    eops8++;
        if (error8)  begin errs8++; lerr8 = err_code8; end
        if (valid16) wq16.push_back(data16);
        if (eop16)   eops16++;
        if (error16) begin errs16++; lerr16 = err_code16; end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic int n_words(input bit sel);
        return sel ? wq16.size() : wq8.size();
    endfunction
    function automatic logic [15:0] word_at(input bit sel, input int i);
        if (sel) return (i < wq16.size()) ? wq16[i] : 'x;
        return (i < wq8.size()) ? wq8[i] : 'x;
    endfunction
    function automatic int n_eops(input bit sel);
        return sel ? eops16 : eops8;
    endfunction
    function automatic int n_errs(input bit sel);
        return sel ? errs16 : errs8;
    endfunction
    function automatic rx_err_t last_err(input bit sel);
        return sel ? lerr16 : lerr8;
    endfunction
    function automatic logic act(input bit sel);
        return sel ? active16 : active8;
    endfunction

    // ---- line-level packet model ----
    function automatic d_port_t flip(input d_port_t l);
        return (l == D_K) ? D_J : D_K;
    endfunction

    task automatic m_sync(input int n);
        for (int i = 0; i < n; i++)
            sq.push_back((i >= n - 2 || i % 2 == 0) ? D_K : D_J);
        lvl  = D_K;
        ones = 0;
    endtask

    // NRZI: a 1 keeps the level, a 0 toggles; optional zero insertion after 6 ones.
    task automatic m_bit(input bit b, input bit stuff);
        if (b) ones++;
        else begin lvl = flip(lvl); ones = 0; end
        sq.push_back(lvl);
        if (stuff && ones == 6) begin
            lvl = flip(lvl);
            sq.push_back(lvl);
            ones = 0;
        end
    endtask

    task automatic m_word(input logic [15:0] w, input int width);
        for (int i = 0; i < width; i++) m_bit(w[i], 1'b1);
    endtask

    task automatic m_eop();
        sq.push_back(D_SE0);
        sq.push_back(D_SE0);
        sq.push_back(D_J);
    endtask

    // ---- drivers ----
    task automatic send_sym(input bit sel, input d_port_t s);
        int gap;
        if (sel) begin rxd16 = s; rxd8 = D_J; end
        else     begin rxd8 = s; rxd16 = D_J; end
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            rxd8  = d_port_t'(2'($urandom_range(0, 3)));
            rxd16 = d_port_t'(2'($urandom_range(0, 3)));
            @(negedge clk);
        end
        rxd8  = D_J;
        rxd16 = D_J;
    endtask

    task automatic play_n(input bit sel, input int n);
        for (int i = 0; i < n && sq.size() > 0; i++) send_sym(sel, sq.pop_front());
    endtask

    task automatic play_all(input bit sel);
        while (sq.size() > 0) send_sym(sel, sq.pop_front());
    endtask

    task automatic settle(input int n);
        clk_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Full packet of expw words plus `extra` trailing bits, checked end to end.
    task automatic pkt_check(input bit sel, input int extra, input string name);
        int width, slen, wb, eb, rb;
        bit bad;
        width = sel ? 16 : 8;
        slen  = sel ? 32 : 8;
        wb = n_words(sel); eb = n_eops(sel); rb = n_errs(sel);
        sq.delete();
        m_sync(slen);
        foreach (expw[i]) m_word(expw[i], width);
        for (int i = 0; i < extra; i++) m_bit(1'($urandom_range(0, 1)), 1'b1);
        m_eop();
        play_n(sel, slen);
        check_n++;
        if (act(sel) !== 1'b1) $display("FAIL %s active_after_sync: got %b required 1", name, act(sel));
        else pass_n++;
        play_all(sel);
        settle(3);
        bad = (extra > 1);
        check_n++;
        if (n_words(sel) - wb != expw.size())
            $display("FAIL %s word_count: got %0d required %0d", name, n_words(sel) - wb, expw.size());
        else pass_n++;
        foreach (expw[i]) begin
            check_n++;
            if (word_at(sel, wb + i) !== expw[i])
                $display("FAIL %s word[%0d]: got %h required %h", name, i, word_at(sel, wb + i), expw[i]);
            else pass_n++;
        end
        check_n++;
        if (n_eops(sel) - eb != (bad ? 0 : 1))
            $display("FAIL %s eop_count: got %0d required %0d", name, n_eops(sel) - eb, bad ? 0 : 1);
        else pass_n++;
        check_n++;
        if (n_errs(sel) - rb != (bad ? 1 : 0))
            $display("FAIL %s error_count: got %0d required %0d", name, n_errs(sel) - rb, bad ? 1 : 0);
        else pass_n++;
        if (bad) begin
            check_n++;
            if (last_err(sel) !== ERR_ALIGN)
                $display("FAIL %s err_code: got %0d required %0d", name, last_err(sel), ERR_ALIGN);
            else pass_n++;
        end
        check_n++;
        if (act(sel) !== 1'b0) $display("FAIL %s active_after_end: got %b required 0", name, act(sel));
        else pass_n++;
        expw.delete();
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        reset = 1'b1; clk_en = 1'b0; rxd8 = D_J; rxd16 = D_J;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_n++;
        if ({valid8, active8, eop8, error8} !== 4'b0)
            $display("FAIL reset_flags8: got %b required 0000", {valid8, active8, eop8, error8});
        else pass_n++;
        check_n++;
        if (data8 !== 8'h00) $display("FAIL reset_data8: got %h required 00", data8);
        else pass_n++;
        check_n++;
        if (err_code8 !== RX_OK) $display("FAIL reset_err8: got %0d required 0", err_code8);
        else pass_n++;
        check_n++;
        if ({valid16, active16, eop16, error16, data16} !== 20'b0)
            $display("FAIL reset_16: got %h required 0", {valid16, active16, eop16, error16, data16});
        else pass_n++;
    endtask

    task automatic test_basic();
        expw.push_back(16'h00A5);
        expw.push_back(16'h003C);
        pkt_check(1'b0, 0, "basic");
    endtask

    task automatic test_stuff_ff();
        int wb, eb, rb;
        wb = n_words(0); eb = n_eops(0); rb = n_errs(0);
        sq.delete();
        m_sync(8);
        m_word(16'h00FF, 8);
        play_n(1'b0, 16);
        check_n++;
        if (n_words(0) != wb) $display("FAIL stuff_ff early_valid: got %0d required %0d", n_words(0), wb);
        else pass_n++;
        play_n(1'b0, 1);
        check_n++;
        if (n_words(0) != wb + 1) $display("FAIL stuff_ff valid_on_9th: got %0d required %0d", n_words(0), wb + 1);
        else pass_n++;
        check_n++;
        if (word_at(0, wb) !== 16'h00FF) $display("FAIL stuff_ff data: got %h required 00ff", word_at(0, wb));
        else pass_n++;
        m_eop();
        play_all(1'b0);
        settle(3);
        check_n++;
        if (n_eops(0) - eb != 1 || n_errs(0) != rb)
            $display("FAIL stuff_ff end: got eop %0d err %0d required eop 1 err 0", n_eops(0) - eb, n_errs(0) - rb);
        else pass_n++;
    endtask

    task automatic test_stuff_err();
        int wb, rb;
        wb = n_words(0); rb = n_errs(0);
        sq.delete();
        m_sync(8);
        for (int i = 0; i < 7; i++) m_bit(1'b1, 1'b0);
        play_all(1'b0);
        settle(2);
        check_n++;
        if (n_errs(0) - rb != 1) $display("FAIL stuff_err count: got %0d required 1", n_errs(0) - rb);
        else pass_n++;
        check_n++;
        if (last_err(0) !== ERR_STUFF) $display("FAIL stuff_err code: got %0d required %0d", last_err(0), ERR_STUFF);
        else pass_n++;
        check_n++;
        if (n_words(0) != wb) $display("FAIL stuff_err no_valid: got %0d required %0d", n_words(0), wb);
        else pass_n++;
        send_sym(1'b0, D_J);
        check_n++;
        if (active8 !== 1'b1) $display("FAIL stuff_err active_in_abort: got %b required 1", active8);
        else pass_n++;
        send_sym(1'b0, D_J);
        settle(2);
        check_n++;
        if (active8 !== 1'b0) $display("FAIL stuff_err active_drop: got %b required 0", active8);
        else pass_n++;
    endtask

    task automatic test_sync_broken();
        int wb, rb;
        wb = n_words(0); rb = n_errs(0);
        sq.delete();
        sq.push_back(D_K); sq.push_back(D_J); sq.push_back(D_K); sq.push_back(D_K);
        sq.push_back(D_J); sq.push_back(D_J); sq.push_back(D_J);
        play_all(1'b0);
        settle(2);
        check_n++;
        if (active8 !== 1'b0 || n_errs(0) != rb || n_words(0) != wb)
            $display("FAIL sync_broken quiet: got active %b err %0d words %0d required 0 0 0",
                     active8, n_errs(0) - rb, n_words(0) - wb);
        else pass_n++;
        expw.push_back(16'($urandom_range(0, 255)));
        expw.push_back(16'($urandom_range(0, 255)));
        pkt_check(1'b0, 0, "sync_recover");
    endtask

    task automatic test_eop_short();
        int wb, eb, rb;
        logic [15:0] b;
        wb = n_words(0); eb = n_eops(0); rb = n_errs(0);
        b = 16'($urandom_range(0, 255));
        sq.delete();
        m_sync(8);
        m_word(b, 8);
        sq.push_back(D_SE0);
        sq.push_back(D_J);
        play_all(1'b0);
        settle(2);
        check_n++;
        if (n_errs(0) - rb != 1 || last_err(0) !== ERR_EOP)
            $display("FAIL eop_short error: got %0d code %0d required 1 code %0d", n_errs(0) - rb, last_err(0), ERR_EOP);
        else pass_n++;
        check_n++;
        if (n_eops(0) != eb || word_at(0, wb) !== b)
            $display("FAIL eop_short state: got eop %0d word %h required eop 0 word %h", n_eops(0) - eb, word_at(0, wb), b);
        else pass_n++;
        send_sym(1'b0, D_J);
        send_sym(1'b0, D_J);
        settle(2);
        check_n++;
        if (active8 !== 1'b0) $display("FAIL eop_short active_drop: got %b required 0", active8);
        else pass_n++;
    endtask

    task automatic test_wide();
        expw.push_back(16'h1234);
        pkt_check(1'b1, 0, "wide_word");
        expw.push_back(16'h1234);
        pkt_check(1'b1, 3, "wide_align");
        expw.push_back(16'($urandom_range(0, 65535)));
        expw.push_back(16'($urandom_range(0, 65535)));
        pkt_check(1'b1, $urandom_range(0, 1), "wide_rand");
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 6; p++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int i = 0; i < nb; i++) expw.push_back(16'($urandom_range(0, 255)));
            pkt_check(1'b0, $urandom_range(0, 3), "b2b");
        end
    endtask

    task automatic test_reset_mid();
        int eb, rb;
        sq.delete();
        m_sync(8);
        for (int i = 0; i < 4; i++) m_bit(1'($urandom_range(0, 1)), 1'b1);
        play_all(1'b0);
        check_n++;
        if (active8 !== 1'b1) $display("FAIL reset_mid active_before: got %b required 1", active8);
        else pass_n++;
        eb = n_eops(0); rb = n_errs(0);
        #2 reset = 1'b1;
        #1;
        check_n++;
        if ({valid8, active8, eop8, error8} !== 4'b0 || data8 !== 8'h00 || err_code8 !== RX_OK)
            $display("FAIL reset_mid async: got flags %b data %h code %0d required 0",
                     {valid8, active8, eop8, error8}, data8, err_code8);
        else pass_n++;
        @(negedge clk);
        reset = 1'b0;
        settle(2);
        check_n++;
        if (n_eops(0) != eb || n_errs(0) != rb)
            $display("FAIL reset_mid no_pulse: got eop %0d err %0d required 0 0", n_eops(0) - eb, n_errs(0) - rb);
        else pass_n++;
        expw.push_back(16'($urandom_range(0, 255)));
        pkt_check(1'b0, 0, "after_reset");
        rb = n_errs(0);
        sq.delete();
        m_sync(8);
        m_word(16'($urandom_range(0, 255)), 8);
        sq.push_back(D_SE1);
        sq.push_back(D_J);
        sq.push_back(D_J);
        play_all(1'b0);
        settle(3);
        check_n++;
        if (n_errs(0) - rb != 1 || last_err(0) !== ERR_SE1)
            $display("FAIL se1 error: got %0d code %0d required 1 code %0d", n_errs(0) - rb, last_err(0), ERR_SE1);
        else pass_n++;
        check_n++;
        if (active8 !== 1'b0) $display("FAIL se1 active_drop: got %b required 0", active8);
        else pass_n++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuff_ff();
        test_stuff_err();
        test_sync_broken();
        test_eop_short();
        test_wide();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, check_n);
        $finish;
    end

endmodule
